mem_port_arbiter: RTL and testbench

Arbitrates the unified instruction/data memory of the multicycle processor between two requesters: the CPU port, which carries fetch, load and store traffic, and a debug/loader port used for program load and memory inspection. Requests are accepted one at a time and sequenced through a single memory access of parameterised read latency. Fixed CPU priority applies, with a starvation guard and a lock input that gives the debug port exclusive ownership.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified instruction/data memory between the CPU port and the
// debug/loader port. One access at a time; CPU has fixed priority, limited
// by a starvation guard, and dbg_lock shuts the CPU out of arbitration.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-low reset
//   cpu_req/we/addr/wdata         CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid, cpu_rdata  CPU accept pulse, read response
//   dbg_req/we/addr/wdata         debug request, same rules as CPU
//   dbg_lock                      1 = CPU never granted
//   dbg_gnt, dbg_rvalid, dbg_rdata  debug accept pulse, read response
//   mem_read, mem_write           memory strobes
//   mem_addr, mem_wdata           latched access address / write data
//   mem_rdata                     memory read data
//   busy                          access or response in progress
//
// state  | meaning
// IDLE   | arbitrate between eligible requesters
// ACCESS | gnt pulse, then write strobe (1 cycle) or read strobe (MEM_LAT cycles)
// RESP   | owner's rvalid pulse with sampled read data
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic              dbg_lock,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int ST_W  = $clog2(STARVE_MAX + 1);
   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_nxt;
   logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
   logic [ST_W-1:0]   starve_cnt, starve_nxt;
   logic              owner_dbg, owner_nxt;
   logic              acc_we, we_nxt;

   logic              cpu_elig, dbg_elig, arb, win_dbg, rd_sample;
   logic              cpu_gnt_d, dbg_gnt_d, cpu_rvalid_d, dbg_rvalid_d;
   logic              mem_read_d, mem_write_d, busy_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d, cpu_rdata_d, dbg_rdata_d;

   assign cpu_elig  = cpu_req && !dbg_lock;
   assign dbg_elig  = dbg_req;
   assign arb       = (state == IDLE) && (cpu_elig || dbg_elig);
   assign win_dbg   = dbg_elig && (!cpu_elig || (starve_cnt == ST_W'(STARVE_MAX)));
   // last read cycle: mem_rdata is captured at the edge that ends it
   assign rd_sample = (state == ACCESS) && !acc_we && (lat_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         owner_dbg  <= 1'b0;
         acc_we     <= 1'b0;
         cpu_gnt    <= 1'b0;
         dbg_gnt    <= 1'b0;
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rdata  <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         lat_cnt    <= lat_cnt_nxt;
         starve_cnt <= starve_nxt;
         owner_dbg  <= owner_nxt;
         acc_we     <= we_nxt;
         cpu_gnt    <= cpu_gnt_d;
         dbg_gnt    <= dbg_gnt_d;
         cpu_rvalid <= cpu_rvalid_d;
         dbg_rvalid <= dbg_rvalid_d;
         cpu_rdata  <= cpu_rdata_d;
         dbg_rdata  <= dbg_rdata_d;
         mem_read   <= mem_read_d;
         mem_write  <= mem_write_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         busy       <= busy_d;
      end
   end

   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      starve_nxt  = starve_cnt;
      owner_nxt   = owner_dbg;
      we_nxt      = acc_we;
      case (state)
         IDLE: begin
            if (arb) begin
               state_nxt   = ACCESS;
               owner_nxt   = win_dbg;
               we_nxt      = win_dbg ? dbg_we : cpu_we;
               lat_cnt_nxt = LAT_W'(MEM_LAT - 1);
               if (win_dbg || !dbg_req)
                  starve_nxt = '0;
               else if (starve_cnt != ST_W'(STARVE_MAX))
                  starve_nxt = starve_cnt + 1'b1;
            end
         end
         ACCESS: begin
            if (acc_we)
               state_nxt = IDLE;
            else if (lat_cnt == '0)
               state_nxt = RESP;
            else
               lat_cnt_nxt = lat_cnt - 1'b1;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered, so this computes the values for the next cycle.
   always_comb begin
      cpu_gnt_d    = arb && !win_dbg;
      dbg_gnt_d    = arb && win_dbg;
      mem_read_d   = (state_nxt == ACCESS) && !we_nxt;
      mem_write_d  = (state == IDLE) && (state_nxt == ACCESS) && we_nxt;
      cpu_rvalid_d = rd_sample && !owner_dbg;
      dbg_rvalid_d = rd_sample && owner_dbg;
      busy_d       = (state_nxt != IDLE);
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      cpu_rdata_d  = cpu_rdata;
      dbg_rdata_d  = dbg_rdata;
      if (arb) begin
         mem_addr_d  = win_dbg ? dbg_addr : cpu_addr;
         mem_wdata_d = win_dbg ? dbg_wdata : cpu_wdata;
      end
      if (rd_sample && !owner_dbg)
         cpu_rdata_d = mem_rdata;
      if (rd_sample && owner_dbg)
         dbg_rdata_d = mem_rdata;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int SM = 4;

   logic        clk;
   logic        rst;
   logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;

   // index 0: MEM_LAT=1 instance, index 1: MEM_LAT=3 instance
   logic        cpu_gnt_o [2];
   logic        cpu_rvalid_o [2];
   logic [31:0] cpu_rdata_o [2];
   logic        dbg_gnt_o [2];
   logic        dbg_rvalid_o [2];
   logic [31:0] dbg_rdata_o [2];
   logic        mem_read_o [2];
   logic        mem_write_o [2];
   logic [31:0] mem_addr_o [2];
   logic [31:0] mem_wdata_o [2];
   logic        busy_o [2];

   int          sel;
   int          lat;
   int          n_tests;
   int          n_fail;

   // reference model state
   int          m_starve;
   logic [31:0] m_cpu_rdata, m_dbg_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SM)) u_lat1 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt_o[0]), .cpu_rvalid(cpu_rvalid_o[0]), .cpu_rdata(cpu_rdata_o[0]),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_lock(dbg_lock),
      .dbg_gnt(dbg_gnt_o[0]), .dbg_rvalid(dbg_rvalid_o[0]), .dbg_rdata(dbg_rdata_o[0]),
      .mem_read(mem_read_o[0]), .mem_write(mem_write_o[0]), .mem_addr(mem_addr_o[0]),
      .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata), .busy(busy_o[0])
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SM)) u_lat3 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt_o[1]), .cpu_rvalid(cpu_rvalid_o[1]), .cpu_rdata(cpu_rdata_o[1]),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_lock(dbg_lock),
      .dbg_gnt(dbg_gnt_o[1]), .dbg_rvalid(dbg_rvalid_o[1]), .dbg_rdata(dbg_rdata_o[1]),
      .mem_read(mem_read_o[1]), .mem_write(mem_write_o[1]), .mem_addr(mem_addr_o[1]),
      .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata), .busy(busy_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cpu_gnt"},    32'(cpu_gnt_o[sel]),    0);
      chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid_o[sel]), 0);
      chk({tag, "_cpu_rdata"},  cpu_rdata_o[sel],       0);
      chk({tag, "_dbg_gnt"},    32'(dbg_gnt_o[sel]),    0);
      chk({tag, "_dbg_rvalid"}, 32'(dbg_rvalid_o[sel]), 0);
      chk({tag, "_dbg_rdata"},  dbg_rdata_o[sel],       0);
      chk({tag, "_mem_read"},   32'(mem_read_o[sel]),   0);
      chk({tag, "_mem_write"},  32'(mem_write_o[sel]),  0);
      chk({tag, "_mem_addr"},   mem_addr_o[sel],        0);
      chk({tag, "_mem_wdata"},  mem_wdata_o[sel],       0);
      chk({tag, "_busy"},       32'(busy_o[sel]),       0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      dbg_lock = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b1;
      m_starve = 0;
      m_cpu_rdata = '0;
      m_dbg_rdata = '0;
   endtask

   // One arbitration from an IDLE cycle using the currently driven inputs.
   // Returns the grant actually observed on the DUT (0 none, 1 cpu, 2 dbg).
   task automatic arbitrate(input bit lock_after, input logic [31:0] fin, output int who);
      int          w;
      logic        we;
      logic [31:0] a, d;
      bit          ce, de;
      ce = cpu_req && !dbg_lock;
      de = dbg_req;
      if (ce && de) w = (m_starve == SM) ? 2 : 1;
      else if (ce)  w = 1;
      else if (de)  w = 2;
      else          w = 0;
      if (w != 0) begin
         if (w == 2 || !dbg_req) m_starve = 0;
         else if (m_starve < SM) m_starve++;
      end
      we = (w == 2) ? dbg_we : cpu_we;
      a  = (w == 2) ? dbg_addr : cpu_addr;
      d  = (w == 2) ? dbg_wdata : cpu_wdata;

      step();
      who = cpu_gnt_o[sel] ? 1 : (dbg_gnt_o[sel] ? 2 : 0);
      chk("gnt_cpu", 32'(cpu_gnt_o[sel]), 32'(w == 1));
      chk("gnt_dbg", 32'(dbg_gnt_o[sel]), 32'(w == 2));
      if (w == 0) begin
         chk("idle_busy",  32'(busy_o[sel]),      0);
         chk("idle_read",  32'(mem_read_o[sel]),  0);
         chk("idle_write", 32'(mem_write_o[sel]), 0);
         return;
      end
      chk("acc_busy",  32'(busy_o[sel]),      1);
      chk("acc_addr",  mem_addr_o[sel],       a);
      chk("acc_wdata", mem_wdata_o[sel],      d);
      chk("acc_write", 32'(mem_write_o[sel]), 32'(we));
      chk("acc_read",  32'(mem_read_o[sel]),  32'(!we));
      if (w == 1) cpu_req = 1'b0;
      else        dbg_req = 1'b0;
      if (lock_after) dbg_lock = 1'b1;

      if (we) begin
         step();
         chk("wr_busy_end", 32'(busy_o[sel]),      0);
         chk("wr_strobe1",  32'(mem_write_o[sel]), 0);
         chk("wr_cpu_rv",   32'(cpu_rvalid_o[sel]), 0);
         chk("wr_dbg_rv",   32'(dbg_rvalid_o[sel]), 0);
      end else begin
         for (int c = 1; c <= lat; c++) begin
            mem_rdata = (c == lat) ? fin : $urandom;
            step();
            if (c < lat) begin
               chk("rd_strobe",   32'(mem_read_o[sel]),   1);
               chk("rd_early_rv", 32'(cpu_rvalid_o[sel] | dbg_rvalid_o[sel]), 0);
               chk("rd_gnt_once", 32'(cpu_gnt_o[sel] | dbg_gnt_o[sel]), 0);
            end
         end
         if (w == 1) m_cpu_rdata = fin;
         else        m_dbg_rdata = fin;
         mem_rdata = $urandom;
         chk("resp_cpu_rv", 32'(cpu_rvalid_o[sel]), 32'(w == 1));
         chk("resp_dbg_rv", 32'(dbg_rvalid_o[sel]), 32'(w == 2));
         chk("resp_cpu_rd", cpu_rdata_o[sel], m_cpu_rdata);
         chk("resp_dbg_rd", dbg_rdata_o[sel], m_dbg_rdata);
         chk("resp_read",   32'(mem_read_o[sel]), 0);
         chk("resp_busy",   32'(busy_o[sel]),     1);
         step();
         chk("post_busy",   32'(busy_o[sel]),     0);
         chk("post_rv",     32'(cpu_rvalid_o[sel] | dbg_rvalid_o[sel]), 0);
         chk("post_cpu_rd", cpu_rdata_o[sel], m_cpu_rdata);
         chk("post_dbg_rd", dbg_rdata_o[sel], m_dbg_rdata);
      end
   endtask

   initial begin
      int who;
      int order [10];
      n_tests = 0;
      n_fail = 0;
      m_starve = 0;
      rst = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      dbg_lock = 1'b0;
      mem_rdata = '0;
      order = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

      // 1: MEM_LAT=1 CPU read
      sel = 0; lat = 1;
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = $urandom;
      arbitrate(1'b0, 32'hDEADBEEF, who);
      chk("t1_who", 32'(who), 1);
      chk("t1_rdata_hold", cpu_rdata_o[sel], 32'hDEADBEEF);

      // 2: debug write, never a read response
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h12345678;
      arbitrate(1'b0, 32'h0, who);
      chk("t2_who", 32'(who), 2);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_no_rvalid", 32'(dbg_rvalid_o[sel]), 0);
         chk("t2_no_write",  32'(mem_write_o[sel]), 0);
      end

      // 3: both held continuously -> starvation guard
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
         cpu_addr = $urandom; cpu_wdata = $urandom;
         if (!dbg_req) begin
            dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = $urandom; dbg_wdata = $urandom;
         end
         arbitrate(1'b0, $urandom, who);
         chk("t3_order", 32'(who), 32'(order[i]));
      end

      // 4: MEM_LAT=3 read with mem_rdata noise before the sample
      sel = 1; lat = 3;
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
      arbitrate(1'b0, $urandom, who);
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = $urandom; dbg_wdata = $urandom;
      arbitrate(1'b0, $urandom, who);
      chk("t4_dbg_read", 32'(who), 2);

      // 5: lock raised during an in-flight CPU read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
      arbitrate(1'b1, $urandom, who);
      chk("t5_inflight", 32'(who), 1);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = $urandom; cpu_wdata = $urandom;
      arbitrate(1'b0, $urandom, who);
      chk("t5_locked_out", 32'(who), 0);
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = $urandom; dbg_wdata = $urandom;
      arbitrate(1'b0, $urandom, who);
      chk("t5_dbg_under_lock", 32'(who), 2);
      dbg_lock = 1'b0;
      arbitrate(1'b0, $urandom, who);
      chk("t5_cpu_after_unlock", 32'(who), 1);

      // 6: reset during ACCESS of a MEM_LAT=3 read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
      step();
      chk("t6_gnt", 32'(cpu_gnt_o[sel]), 1);
      cpu_req = 1'b0;
      step();
      chk("t6_in_access", 32'(mem_read_o[sel]), 1);
      rst = 1'b0;
      step();
      chk_all_zero("t6_abort");
      rst = 1'b1;
      m_starve = 0; m_cpu_rdata = '0; m_dbg_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_no_rvalid", 32'(cpu_rvalid_o[sel]), 0);
         chk("t6_idle", 32'(busy_o[sel]), 0);
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
      arbitrate(1'b0, $urandom, who);
      chk("t6_fresh", 32'(who), 1);

      // randomized traffic on both latencies
      for (int s = 0; s < 2; s++) begin
         sel = s; lat = (s == 0) ? 1 : 3;
         do_reset();
         for (int i = 0; i < 40; i++) begin
            if (cpu_req && $urandom_range(0, 9) == 0) cpu_req = 1'b0;
            else if (!cpu_req && $urandom_range(0, 2) != 0) begin
               cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
               cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            if (dbg_req && $urandom_range(0, 9) == 0) dbg_req = 1'b0;
            else if (!dbg_req && $urandom_range(0, 2) != 0) begin
               dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
               dbg_addr = $urandom; dbg_wdata = $urandom;
            end
            dbg_lock = ($urandom_range(0, 5) == 0);
            arbitrate(1'b0, $urandom, who);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
